mrv32_ctrl: RTL and testbench

- Multi-cycle control sequencer for the MRV32 core.
- Drives instruction fetch, IR latch, execute, data-memory access, register writeback and PC update, one instruction at a time.
- Consumes the instruction decoder's class flags and handshakes with the instruction and data memories.
- Counts retired instructions and traps sticky on illegal instructions or memory timeouts.

---
 rtl/mrv32_ctrl_if.sv | 39 +++
 rtl/mrv32_ctrl.sv | 135 +++++++++++++
 tb/tb_mrv32_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mrv32_ctrl_if.sv
// Control-sequencer bus: run, memory handshakes, decoder flags and datapath strobes.
// master = sequencer side, slave = datapath/memory side.
interface mrv32_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             imem_req;
  logic             imem_ready;
  logic             ir_wen;
  logic             dec_mem_ren;
  logic             dec_mem_wen;
  logic             dec_reg_wen;
  logic             dec_is_jal;
  logic             dec_unsupported;
  logic             alu_wen;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ready;
  logic             rf_wen;
  logic             pc_wen;
  logic             pc_sel;
  logic [CNT_W-1:0] instret;
  logic             halt;
  logic [1:0]       halt_cause;

  modport master (
    input  run, imem_ready, dmem_ready,
    input  dec_mem_ren, dec_mem_wen, dec_reg_wen, dec_is_jal, dec_unsupported,
    output imem_req, ir_wen, alu_wen, dmem_req, dmem_we, rf_wen, pc_wen, pc_sel,
    output instret, halt, halt_cause
  );

  modport slave (
    output run, imem_ready, dmem_ready,
    output dec_mem_ren, dec_mem_wen, dec_reg_wen, dec_is_jal, dec_unsupported,
    input  imem_req, ir_wen, alu_wen, dmem_req, dmem_we, rf_wen, pc_wen, pc_sel,
    input  instret, halt, halt_cause
  );
endinterface

// File: rtl/mrv32_ctrl.sv
// MRV32 multi-cycle sequencer: FETCH, DECODE, EXEC, [MEM], WB per instruction.
// Counts retired instructions; traps sticky on illegal encodings or memory timeouts.
module mrv32_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mrv32_ctrl_if.master bus
);
  localparam int            TW      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic          TO_EN   = (MEM_TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t           r_state, w_next;
  logic             r_mem_ren, r_mem_wen, r_reg_wen, r_is_jal;
  logic [1:0]       r_cause, w_cause;
  logic [TW-1:0]    r_tcnt;
  logic [CNT_W-1:0] r_instret;
  logic             w_fetch_to, w_mem_to;

  // Trap fires on the MEM_TIMEOUT-th request cycle that still has no ready.
  assign w_fetch_to = TO_EN && (r_tcnt == TO_LAST) && !bus.imem_ready;
  assign w_mem_to   = TO_EN && (r_tcnt == TO_LAST) && !bus.dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    w_cause         = r_cause;
    bus.imem_req    = 1'b0;
    bus.ir_wen      = 1'b0;
    bus.alu_wen     = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_we     = 1'b0;
    bus.rf_wen      = 1'b0;
    bus.pc_wen      = 1'b0;
    bus.pc_sel      = 1'b0;
    bus.halt        = 1'b0;
    bus.halt_cause  = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (bus.run) w_next = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_wen   = bus.imem_ready;
        if (bus.imem_ready) begin
          w_next = S_DECODE;
        end else if (w_fetch_to) begin
          w_next  = S_HALT;
          w_cause = 2'b10;
        end
      end
      S_DECODE: begin
        if (bus.dec_unsupported) begin
          w_next  = S_HALT;
          w_cause = 2'b01;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.alu_wen = 1'b1;
        w_next      = (r_mem_ren || r_mem_wen) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = r_mem_wen;
        if (bus.dmem_ready) begin
          w_next = S_WB;
        end else if (w_mem_to) begin
          w_next  = S_HALT;
          w_cause = 2'b11;
        end
      end
      S_WB: begin
        // A latched store wins over a load, so it never writes rd.
        bus.rf_wen = r_reg_wen && !r_mem_wen;
        bus.pc_wen = 1'b1;
        bus.pc_sel = r_is_jal;
        w_next     = bus.run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        bus.halt       = 1'b1;
        bus.halt_cause = r_cause;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_ren <= 1'b0;
      r_mem_wen <= 1'b0;
      r_reg_wen <= 1'b0;
      r_is_jal  <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_mem_ren <= bus.dec_mem_ren;
      r_mem_wen <= bus.dec_mem_wen;
      r_reg_wen <= bus.dec_reg_wen;
      r_is_jal  <= bus.dec_is_jal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if ((r_state == S_FETCH && !bus.imem_ready) ||
                 (r_state == S_MEM   && !bus.dmem_ready)) begin
      r_tcnt <= r_tcnt + TW'(1);
    end else begin
      r_tcnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cause   <= 2'b00;
      r_instret <= '0;
    end else begin
      r_cause <= w_cause;
      if (r_state == S_WB) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign bus.instret = r_instret;
endmodule

// File: tb/tb_mrv32_ctrl.sv
// Randomized bench for mrv32_ctrl: an instruction-level model predicts every cycle's
// strobes from the instruction class and memory wait counts.
module tb_mrv32_ctrl;
  localparam int TO    = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tot = 0;
  int   n_bad = 0;
  logic [CNT_W-1:0] exp_ret;

  always #5 clk = ~clk;

  mrv32_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mrv32_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [10:0] obs;
  assign obs = {bus.imem_req, bus.ir_wen, bus.alu_wen, bus.dmem_req, bus.dmem_we,
                bus.rf_wen, bus.pc_wen, bus.pc_sel, bus.halt, bus.halt_cause};

  function automatic logic [10:0] ov(input logic req, ir, alu, dreq, dwe, rf, pcw, pcs,
                                     hlt, input logic [1:0] cs);
    return {req, ir, alu, dreq, dwe, rf, pcw, pcs, hlt, cs};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs the sequencer must ignore in the current cycle get random values.
  task automatic garbage();
    bus.run             = 1'($urandom);
    bus.imem_ready      = 1'($urandom);
    bus.dmem_ready      = 1'($urandom);
    bus.dec_mem_ren     = 1'($urandom);
    bus.dec_mem_wen     = 1'($urandom);
    bus.dec_reg_wen     = 1'($urandom);
    bus.dec_is_jal      = 1'($urandom);
    bus.dec_unsupported = 1'($urandom);
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic step(input string tag, input logic [10:0] exp);
    #1;
    check(tag, 32'(obs), 32'(exp));
    check({tag, "_ret"}, 32'(bus.instret), 32'(exp_ret));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Ends at a falling edge with the sequencer in FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out", 32'(obs), 32'd0);
    check("rst_ret", 32'(bus.instret), 32'd0);
    exp_ret = '0;
    @(negedge clk);
    rst_n = 1'b1;
    garbage(); bus.run = 1'b0;
    step("idle", '0);
    garbage(); bus.run = 1'b1;
    step("idle_go", '0);
  endtask

  task automatic check_halt(input logic [1:0] cs, input int n);
    for (int i = 0; i < n; i++) begin
      garbage();
      bus.run = 1'b1;
      step("halt", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, cs));
    end
  endtask

  // One instruction from FETCH; wi/wd are wait cycles before ready (>= TO means timeout).
  // hc returns the trap cause, 0 when the instruction retires.
  task automatic do_instr(input logic ren, wen, rw, jal, uns, input int wi, wd,
                          input logic run_after, output logic [1:0] hc);
    logic done;
    hc   = 2'b00;
    done = 1'b0;
    for (int c = 0; c < TO; c++) begin
      garbage();
      bus.imem_ready = (c == wi);
      step("fetch", ov(1, c == wi, 0, 0, 0, 0, 0, 0, 0, 2'b00));
      if (c == wi) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      hc = 2'b10;
      return;
    end
    garbage();
    bus.dec_mem_ren = ren; bus.dec_mem_wen = wen; bus.dec_reg_wen = rw;
    bus.dec_is_jal = jal; bus.dec_unsupported = uns;
    step("decode", '0);
    if (uns) begin
      hc = 2'b01;
      return;
    end
    garbage();
    step("exec", ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
    if (ren || wen) begin
      done = 1'b0;
      for (int c = 0; c < TO; c++) begin
        garbage();
        bus.dmem_ready = (c == wd);
        step("mem", ov(0, 0, 0, 1, wen, 0, 0, 0, 0, 2'b00));
        if (c == wd) begin
          done = 1'b1;
          break;
        end
      end
      if (!done) begin
        hc = 2'b11;
        return;
      end
    end
    garbage();
    bus.run = run_after;
    step("wb", ov(0, 0, 0, 0, 0, rw && !wen, 1, jal, 0, 2'b00));
    exp_ret = exp_ret + 1'b1;
  endtask

  // Brings the sequencer back to FETCH after an instruction ends.
  task automatic resume(input logic [1:0] hc, input logic run_after, input int nhalt);
    if (hc != 2'b00) begin
      check_halt(hc, nhalt);
      do_reset();
    end else if (!run_after) begin
      garbage(); bus.run = 1'b0;
      step("idle_stay", '0);
      garbage(); bus.run = 1'b1;
      step("idle_go", '0);
    end
  endtask

  initial begin
    logic [1:0] hc;
    logic ren, wen, rw, jal, uns, ra;
    int wi, wd;
    rst_n = 1'b0;
    exp_ret = '0;
    garbage();
    do_reset();

    // ADDI, LW with 3 waits, SW, JAL rd/x0
    do_instr(0, 0, 1, 0, 0, 0, 0, 1, hc); resume(hc, 1, 0);
    do_instr(1, 0, 1, 0, 0, 0, 3, 1, hc); resume(hc, 1, 0);
    do_instr(0, 1, 0, 0, 0, 0, 0, 1, hc); resume(hc, 1, 0);
    do_instr(0, 0, 1, 1, 0, 1, 0, 1, hc); resume(hc, 1, 0);
    do_instr(0, 0, 0, 1, 0, 0, 0, 1, hc); resume(hc, 1, 0);
    // load+store both latched behaves as a store
    do_instr(1, 1, 0, 0, 0, 0, 1, 1, hc); resume(hc, 1, 0);
    // run dropped during a MEM wait: retires then idles
    do_instr(1, 0, 1, 0, 0, 0, 2, 0, hc); resume(hc, 0, 0);
    // ready on the last allowed cycle wins
    do_instr(0, 0, 1, 0, 0, TO - 1, 0, 1, hc); resume(hc, 1, 0);
    do_instr(1, 0, 1, 0, 0, 0, TO - 1, 1, hc); resume(hc, 1, 0);
    // illegal: sticky for 100 cycles
    do_instr(0, 0, 1, 0, 1, 0, 0, 1, hc);
    check("illegal_cause", 32'(hc), 32'd1);
    resume(hc, 1, 100);
    // fetch and data timeouts
    do_instr(0, 0, 1, 0, 0, TO, 0, 1, hc);
    check("imem_to_cause", 32'(hc), 32'd2);
    resume(hc, 1, 3);
    do_instr(0, 1, 0, 0, 0, 0, TO, 1, hc);
    check("dmem_to_cause", 32'(hc), 32'd3);
    resume(hc, 1, 3);
    // async reset in the middle of a fetch wait
    do_instr(0, 0, 1, 0, 0, 0, 0, 1, hc); resume(hc, 1, 0);
    garbage(); bus.imem_ready = 1'b0;
    #1;
    check("fetch_wait_req", 32'(bus.imem_req), 32'd1);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      ren = ($urandom_range(0, 3) == 0);
      wen = ($urandom_range(0, 3) == 0);
      rw  = (wen) ? 1'b0 : 1'($urandom);
      jal = (!ren && !wen) ? 1'($urandom) : 1'b0;
      uns = ($urandom_range(0, 24) == 0);
      wi  = ($urandom_range(0, 29) == 0) ? TO : int'($urandom_range(0, TO - 1));
      wd  = ($urandom_range(0, 29) == 0) ? TO : int'($urandom_range(0, TO - 1));
      ra  = ($urandom_range(0, 7) != 0);
      do_instr(ren, wen, rw, jal, uns, wi, wd, ra, hc);
      resume(hc, ra, 2);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
